// File: rtl/flop_load_arbiter.sv
// Shares one DATA_W-bit register among NUM_REQ requesters via a request/grant handshake
// with bounded lock tenures. Define FLOP_LOAD_ARB_FIXED_PRIO_EN for fixed-priority arbitration.
module flop_load_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_LOCK = 4,
    parameter int unsigned ID_W     = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*DATA_W-1:0] din,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         q,
    output logic                      q_valid,
    output logic [ID_W-1:0]           q_src
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [7:0]      MAX_C = 8'(MAX_LOCK);
    localparam logic [ID_W-1:0] LAST  = ID_W'(NUM_REQ - 1);

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    gidx_q, gidx_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]  q_q;
    logic               q_valid_q;
    logic [ID_W-1:0]    q_src_q;

    logic               sel_found;
    logic [ID_W-1:0]    sel_idx;
    logic [ID_W-1:0]    ptr_after;
    logic [DATA_W-1:0]  din_g;
    logic               load;
    logic               req_g;
    logic               lock_g;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!sel_found && req[idx]) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        din_g = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == ID_W'(i)) din_g = din[i*DATA_W +: DATA_W];
        end
    end

`ifdef FLOP_LOAD_ARB_FIXED_PRIO_EN
    assign ptr_after = '0;
`else
    assign ptr_after = (gidx_q == LAST) ? '0 : gidx_q + ID_W'(1);
`endif

    assign req_g  = req[gidx_q];
    assign lock_g = lock[gidx_q];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (sel_found) begin
                    grant_d[sel_idx] = 1'b1;
                    gidx_d           = sel_idx;
                    state_d          = GRANT;
                end
            end
            GRANT: begin
                // Pointer advances whether the grant is used or abandoned.
                ptr_d = ptr_after;
                if (req_g) begin
                    load = 1'b1;
                    if (lock_g) begin
                        state_d = LOCKED;
                        cnt_d   = 8'd1;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end else begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (req_g && cnt_q < MAX_C) begin
                    load  = 1'b1;
                    ptr_d = ptr_after;
                end
                if (!req_g || !lock_g || cnt_q == MAX_C) begin
                    grant_d = '0;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                grant_d = '0;
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            cnt_q     <= 8'd0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            q_src_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            q_valid_q <= load;
            if (load) begin
                q_q     <= din_g;
                q_src_q <= gidx_q;
            end
        end
    end

    assign grant   = grant_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign q_src   = q_src_q;

endmodule

// File: tb/tb_flop_load_arbiter.sv
// Randomized self-checking bench for flop_load_arbiter against a tenure-level reference model.
// Honours FLOP_LOAD_ARB_FIXED_PRIO_EN in the model when the macro is defined.
module tb_flop_load_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int MAXL = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] din;
    logic [N-1:0]   grant;
    logic [W-1:0]   q;
    logic           q_valid;
    logic [1:0]     q_src;

    flop_load_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (W),
        .MAX_LOCK(MAXL),
        .ID_W    (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .lock   (lock),
        .din    (din),
        .grant  (grant),
        .q      (q),
        .q_valid(q_valid),
        .q_src  (q_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: who owns the register, whether the grant is still unused, loads this tenure.
    int         m_owner;
    bit         m_fresh;
    int         m_loads;
    int         m_ptr;
    logic [7:0] m_q;
    bit         m_qv;
    int         m_src;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_grant();
        return (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_fresh = 0; m_loads = 0; m_ptr = 0;
        m_q = 8'h00; m_qv = 0; m_src = 0;
    endtask

    task automatic model_load(input int g);
        m_q   = din[g*W +: W];
        m_qv  = 1;
        m_src = g;
    endtask

    task automatic model_edge();
        int g;
        m_qv = 0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                g = (m_ptr + k) % N;
                if (m_owner < 0 && req[g]) begin
                    m_owner = g;
                    m_fresh = 1;
                end
            end
        end else if (m_fresh) begin
            g = m_owner;
`ifdef FLOP_LOAD_ARB_FIXED_PRIO_EN
            m_ptr = 0;
`else
            m_ptr = (g + 1) % N;
`endif
            m_fresh = 0;
            if (req[g]) begin
                model_load(g);
                if (lock[g]) m_loads = 1;
                else m_owner = -1;
            end else begin
                m_owner = -1;
            end
        end else begin
            g = m_owner;
            if (req[g] && m_loads < MAXL) model_load(g);
            if (!req[g] || !lock[g] || m_loads == MAXL) begin
                m_owner = -1;
                m_loads = 0;
            end else begin
                m_loads++;
            end
        end
    endtask

    task automatic check_outputs();
        check_val("grant", 32'(grant), 32'(m_grant()));
        check_val("q", 32'(q), 32'(m_q));
        check_val("q_valid", 32'(q_valid), 32'(m_qv));
        check_val("q_src", 32'(q_src), 32'(m_src));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any edge.
    task automatic async_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_val("rst_grant", 32'(grant), 32'h0);
        check_val("rst_q", 32'(q), 32'h0);
        check_val("rst_q_valid", 32'(q_valid), 32'h0);
        check_val("rst_q_src", 32'(q_src), 32'h0);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic set_din(input int i, input logic [7:0] v);
        din[i*W +: W] = v;
    endtask

    logic [7:0] lock_seq [6];
    logic [3:0] exp_g;

    initial begin
        req = '0; lock = '0; din = '0; rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        async_reset();
        tick();

        // Single requester
        set_din(1, 8'h44);
        req = 4'b0010;
        tick();
        check_val("single_grant", 32'(grant), 32'h2);
        tick();
        check_val("single_q", 32'(q), 32'h44);
        check_val("single_src", 32'(q_src), 32'h1);
        check_val("single_grant_drop", 32'(grant), 32'h0);
        req = '0;
        tick();

        // Lock limit: pointer now at 2, so requester 2 wins first
        req = 4'b0101; lock = 4'b0100; set_din(0, 8'h5A);
        lock_seq = '{8'h33, 8'h33, 8'hFF, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 6; i++) begin
            set_din(2, lock_seq[i]);
            tick();
        end
        check_val("lock_release_q", 32'(q), 32'h77);
        tick();
        check_val("lock_next_grant", 32'(grant), 32'h1);
        req = '0; lock = '0;
        tick(); tick();

        // All requesting from reset
        async_reset();
        for (int i = 0; i < N; i++) set_din(i, 8'(8'h11 * (i + 1)));
        req = 4'b1111;
        for (int i = 0; i < 10; i++) tick();
        req = '0;
        tick();

        // Abandon
        async_reset();
        req = 4'b1000;
        tick();
        check_val("abandon_grant", 32'(grant), 32'h8);
        req = 4'b0001;
        tick();
        check_val("abandon_qv", 32'(q_valid), 32'h0);
        check_val("abandon_q", 32'(q), 32'h0);
        tick();
        check_val("abandon_next", 32'(grant), 32'h1);
        req = '0;
        tick(); tick();

        // Two-requester arbitration pattern
        async_reset();
        req = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i % 2 == 0) begin
`ifdef FLOP_LOAD_ARB_FIXED_PRIO_EN
                exp_g = 4'b0010;
`else
                exp_g = (i % 4 == 0) ? 4'b0010 : 4'b1000;
`endif
                check_val("pattern_grant", 32'(grant), 32'(exp_g));
            end
        end
        req = '0;
        tick();

        // Reset mid-lock
        async_reset();
        req = 4'b0100; lock = 4'b0100; set_din(2, 8'hC3);
        tick(); tick(); tick();
        async_reset();
        for (int i = 0; i < 8; i++) tick();
        req = '0; lock = '0;
        tick();

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 800; i++) begin
            req  = 4'($urandom);
            lock = 4'($urandom) | 4'($urandom);
            din  = {$urandom};
            if ($urandom_range(0, 99) == 0) async_reset();
            else tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
